// File: rtl/result_reader.sv
// Streams a contiguous feature-map BRAM window out over a valid/ready port.
// Define RESULT_READER_CHECKSUM_EN to build the 16-bit running byte-sum output.
module result_reader #(
  parameter int width      = 8,
  parameter int memaddrbit = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [memaddrbit-1:0] base_addr,
  input  logic [15:0]           length,
  output logic                  mem_en,
  output logic [memaddrbit-1:0] mem_addr,
  input  logic [width-1:0]      mem_dout,
  output logic [width-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            state,
  output logic [15:0]           checksum
);

  localparam logic [7:0] S_IDLE  = 8'd0;
  localparam logic [7:0] S_READ  = 8'd1;
  localparam logic [7:0] S_DRAIN = 8'd2;
  localparam logic [7:0] S_DONE  = 8'd3;

  logic [7:0]            r_state;
  logic [7:0]            w_next;
  logic [memaddrbit-1:0] r_addr;
  logic [15:0]           r_len;
  logic [15:0]           r_iss;
  logic [15:0]           r_acc;
  logic                  r_infl;
  logic [width-1:0]      r_fifo [2];
  logic                  r_rd;
  logic                  r_wr;
  logic [1:0]            r_cnt;

  logic       w_accept;
  logic       w_valid;
  logic       w_pop;
  logic [2:0] w_occ;
  logic       w_credit;
  logic       w_issue;
  logic [width-1:0] w_head;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_valid  = (r_cnt != 2'd0);
  assign w_pop    = w_valid && out_ready;
  assign w_head   = w_valid ? r_fifo[r_rd] : '0;

  // Reads in flight hold a FIFO slot until their data lands.
  assign w_occ    = {1'b0, r_cnt} + {2'b00, r_infl};
  assign w_credit = (w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop);
  assign w_issue  = (r_state == S_READ) && (r_iss != r_len) && w_credit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (length == 16'd0) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (w_issue && (r_iss + 16'd1 == r_len)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_acc + {15'd0, w_pop} == r_len) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = w_issue;
    mem_addr  = r_addr;
    out_valid = w_valid;
    out_data  = w_head;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    state     = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_iss     <= '0;
      r_acc     <= '0;
      r_infl    <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_cnt     <= '0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= base_addr;
        r_len  <= length;
        r_iss  <= '0;
        r_acc  <= '0;
      end else begin
        if (w_issue) begin
          r_addr <= r_addr + 1'b1;
          r_iss  <= r_iss + 16'd1;
        end
        if (w_pop) r_acc <= r_acc + 16'd1;
      end
      r_infl <= w_issue;
      if (r_infl) begin
        r_fifo[r_wr] <= mem_dout;
        r_wr         <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
    end
  end

`ifdef RESULT_READER_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst)           r_sum <= '0;
    else if (w_accept) r_sum <= '0;
    else if (w_pop)    r_sum <= r_sum + 16'(w_head);
  end

  assign checksum = r_sum;
`else
  assign checksum = 16'd0;
`endif

endmodule
